uart_tx_scheduler: RTL and testbench
====================================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 2: idle cycles inserted after each frame completes (0..15).
REQ-002 The block SHALL have parameter BUSY_TIMEOUT, default 4: cycles to wait for tx_busy to rise after tx_start (1..15).
REQ-003 The block SHALL have port clock_10KHz, input, 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset_n, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port req, input, 4: bit i high means requester i has a byte pending.
REQ-006 The block SHALL have port req_last, input, 4: bit i high means requester i's pending byte ends its message.
REQ-007 The block SHALL have port req_data, input, 32: requester i's byte on bits [8i+7:8i].
REQ-008 The block SHALL have port ack, output, 4: one-cycle pulse on bit i when requester i's byte is accepted.
REQ-009 The block SHALL have port grant, output, 2: index of the current owner.
REQ-010 The block SHALL have port grant_valid, output, 1: high while an owner holds the transmitter.
REQ-011 The block SHALL have port tx_start, output, 1: one-cycle pulse launching a frame on the transmitter.
REQ-012 The block SHALL have port tx_data, output, 8: byte to transmit, registered and stable from tx_start until the next tx_start.
REQ-013 The block SHALL have port tx_busy, input, 1: high while the transmitter is sending a frame.
REQ-014 The block SHALL have port err, output, 1: one-cycle pulse on a tx_busy timeout.

Function
REQ-015 The block SHALL implement states IDLE, SEND, WAIT_BUSY, WAIT_DONE, GAP and HOLD, all registered.
REQ-016 In IDLE with req nonzero, the block SHALL pick the first set bit searching upward from rr_ptr (wrapping 3 to 0), register grant, set grant_valid, and go to SEND next cycle.
REQ-017 In SEND with tx_busy low, the block SHALL pulse tx_start and ack[grant] together for one cycle, load tx_data from req_data[grant], capture req_last[grant], and go to WAIT_BUSY; with tx_busy high it SHALL stay in SEND.
REQ-018 In SEND, if req[grant] has dropped, the block SHALL not start a frame and SHALL go to HOLD.
REQ-019 WAIT_BUSY SHALL go to WAIT_DONE on tx_busy high; after BUSY_TIMEOUT cycles without it, the block SHALL pulse err, release the grant, and go to IDLE.
REQ-020 WAIT_DONE SHALL wait for tx_busy low, then go to GAP; GAP SHALL count GAP_CYCLES cycles, and with GAP_CYCLES=0 SHALL last zero cycles.
REQ-021 On leaving GAP with the captured last set, the block SHALL clear grant_valid, set rr_ptr to grant+1 modulo 4, and go to IDLE; otherwise it SHALL go to HOLD.
REQ-022 HOLD SHALL go to SEND when req[grant] is high, and SHALL otherwise wait indefinitely with the grant held.
REQ-023 Requests from non-owners SHALL never produce ack and SHALL be served only after the grant is released.
REQ-024 At most one ack bit SHALL be high in any cycle, and ack SHALL never coincide with err.
REQ-025 The gap and timeout counters SHALL be 4-bit, saturate at their limit, and clear on state entry.

Reset
REQ-026 While Reset_n is low, regardless of the cycle in progress, the block SHALL set state=IDLE, rr_ptr=0, grant=0, grant_valid=0, ack=0, tx_start=0, tx_data=8'h00, err=0, and clear all counters.
REQ-027 After reset release, the block SHALL begin arbitration on the first rising edge with req nonzero.

Configuration
REQ-028 With UART_SCHED_MSG_LOCK_EN defined, the block SHALL hold the grant until a byte with req_last is sent, as in REQ-021/022.
REQ-029 Without UART_SCHED_MSG_LOCK_EN, the block SHALL ignore req_last, release the grant after every byte (GAP goes to IDLE, rr_ptr=grant+1), and not use HOLD.

Verification
REQ-030 With req=4'b0001, data 8'h41, last=1, and a model transmitter at 10 cycles busy: tx_start once, tx_data=8'h41, ack=4'b0001, and the next tx_start no earlier than busy fall+2 cycles.
REQ-031 With req=4'b1010 asserted together from reset: requester 1 is served first, then requester 3, then requester 1 again, each with last=1.
REQ-032 With the lock macro defined, requester 0 sending 3 bytes (last on the third) while req[2] is held: no ack[2] until after the third byte's GAP.
REQ-033 With the lock macro undefined, the same stimulus gives ack order 0,2,0,2,0.
REQ-034 With tx_busy tied low: err pulses 4 cycles after tx_start, grant_valid falls, and the block re-arbitrates.
REQ-035 Reset_n pulsed low in WAIT_DONE: all outputs return to reset values asynchronously, and the state returns to IDLE with rr_ptr=0.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter that feeds bytes from four requesters
// into a single UART transmitter, with a busy-rise timeout and an inter-frame gap.
// Optional feature macro: UART_SCHED_MSG_LOCK_EN keeps the grant for a whole
// message (until a byte flagged last has been sent); without it the grant is
// released after every byte.
module uart_tx_scheduler #(
    parameter int unsigned GAP_CYCLES   = 2,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic        clock_10KHz,
    input  logic        Reset_n,
    input  logic [3:0]  req,
    input  logic [3:0]  req_last,
    input  logic [31:0] req_data,
    output logic [3:0]  ack,
    output logic [1:0]  grant,
    output logic        grant_valid,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic        err
);

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StWaitBusy,
        StWaitDone,
        StGap,
        StHold
    } state_e;

    state_e      r_state;
    logic [1:0]  r_rr_ptr;
    logic [1:0]  r_grant;
    logic        r_grant_valid;
    logic [3:0]  r_ack;
    logic        r_tx_start;
    logic [7:0]  r_tx_data;
    logic        r_err;
    logic [3:0]  r_cnt;
`ifdef UART_SCHED_MSG_LOCK_EN
    logic        r_last;
`else
    // req_last has no meaning when every byte releases the grant
    logic        w_unused_last;
    assign w_unused_last = ^req_last;
`endif

    logic [1:0]  w_pick;
    logic        w_pick_valid;
    logic [3:0]  w_cnt_inc;
    logic        w_frame_end;

    // Round-robin pick: first requester at or above rr_ptr, wrapping 3 -> 0
    always_comb begin
        logic [1:0] idx;
        w_pick       = r_rr_ptr;
        w_pick_valid = 1'b0;
        idx          = r_rr_ptr;
        // Walk offsets downward so the smallest offset wins
        for (int k = 3; k >= 0; k--) begin
            idx = r_rr_ptr + 2'(k);
            if (req[idx]) begin
                w_pick       = idx;
                w_pick_valid = 1'b1;
            end
        end
    end

    // Shared saturating increment for the gap and timeout counter
    always_comb begin
        w_cnt_inc = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
    end

    // Frame completion: end of the gap, or busy fall directly when there is no gap
    always_comb begin
        w_frame_end = 1'b0;
        if (GAP_CYCLES == 0) begin
            w_frame_end = (r_state == StWaitDone) && !tx_busy;
        end else begin
            w_frame_end = (r_state == StGap) && (r_cnt == 4'(GAP_CYCLES - 1));
        end
    end

    // Scheduler FSM with registered outputs
    always_ff @(posedge clock_10KHz or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state       <= StIdle;
            r_rr_ptr      <= 2'd0;
            r_grant       <= 2'd0;
            r_grant_valid <= 1'b0;
            r_ack         <= 4'd0;
            r_tx_start    <= 1'b0;
            r_tx_data     <= 8'h00;
            r_err         <= 1'b0;
            r_cnt         <= 4'd0;
`ifdef UART_SCHED_MSG_LOCK_EN
            r_last        <= 1'b0;
`endif
        end else begin
            // Pulses last exactly one cycle
            r_ack      <= 4'd0;
            r_tx_start <= 1'b0;
            r_err      <= 1'b0;

            unique case (r_state)
                StIdle: begin
                    if (w_pick_valid) begin
                        r_grant       <= w_pick;
                        r_grant_valid <= 1'b1;
                        r_state       <= StSend;
                    end
                end
                StSend: begin
                    if (!req[r_grant]) begin
`ifdef UART_SCHED_MSG_LOCK_EN
                        r_state       <= StHold;
`else
                        // Owner withdrew: give the transmitter back without a frame
                        r_grant_valid <= 1'b0;
                        r_state       <= StIdle;
`endif
                    end else if (!tx_busy) begin
                        r_tx_start <= 1'b1;
                        r_ack      <= 4'b0001 << r_grant;
                        r_tx_data  <= req_data[{r_grant, 3'b000} +: 8];
`ifdef UART_SCHED_MSG_LOCK_EN
                        r_last     <= req_last[r_grant];
`endif
                        r_cnt      <= 4'd0;
                        r_state    <= StWaitBusy;
                    end
                end
                StWaitBusy: begin
                    if (tx_busy) begin
                        r_cnt   <= 4'd0;
                        r_state <= StWaitDone;
                    end else if (r_cnt == 4'(BUSY_TIMEOUT - 1)) begin
                        r_err         <= 1'b1;
                        r_grant_valid <= 1'b0;
                        r_state       <= StIdle;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                StWaitDone: begin
                    if (!tx_busy) begin
                        r_cnt   <= 4'd0;
                        r_state <= StGap;
                    end
                end
                StGap: begin
                    r_cnt <= w_cnt_inc;
                end
                StHold: begin
                    if (req[r_grant]) begin
                        r_state <= StSend;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase

            // Leaving the gap overrides the per-state next state above
            if (w_frame_end) begin
`ifdef UART_SCHED_MSG_LOCK_EN
                if (r_last) begin
                    r_grant_valid <= 1'b0;
                    r_rr_ptr      <= r_grant + 2'd1;
                    r_state       <= StIdle;
                end else begin
                    r_state       <= StHold;
                end
`else
                r_grant_valid <= 1'b0;
                r_rr_ptr      <= r_grant + 2'd1;
                r_state       <= StIdle;
`endif
            end
        end
    end

    assign ack         = r_ack;
    assign grant       = r_grant;
    assign grant_valid = r_grant_valid;
    assign tx_start    = r_tx_start;
    assign tx_data     = r_tx_data;
    assign err         = r_err;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: stimulus queues requester bytes and
// pushes the expected frame/err sequence; a monitor pops and compares whenever
// the DUT pulses tx_start or err. A model transmitter drives tx_busy.
module tb_uart_tx_scheduler;

    localparam int GAP      = 2;
    localparam int TOUT     = 4;
    localparam int BUSY_LEN = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = 4'd0;
    logic [3:0]  req_last = 4'd0;
    logic [31:0] req_data = 32'd0;
    logic [3:0]  ack;
    logic [1:0]  grant;
    logic        grant_valid;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy = 1'b0;
    logic        err;

    typedef struct packed {
        logic       is_err;
        logic [1:0] idx;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] rq[4][$];    // {last, data} per requester
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    bit         busy_dead = 1'b0;
    int         busy_cnt = 0;
    int         last_start_cyc = 0;
    int         last_fall_cyc = 0;
    bit         fall_seen = 1'b0;

    uart_tx_scheduler dut (
        .clock_10KHz(clk),
        .Reset_n    (rst_n),
        .req        (req),
        .req_last   (req_last),
        .req_data   (req_data),
        .ack        (ack),
        .grant      (grant),
        .grant_valid(grant_valid),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Present the head of each requester queue on req/req_last/req_data
    task automatic update_req();
        for (int i = 0; i < 4; i++) begin
            if (rq[i].size() > 0) begin
                req[i]            = 1'b1;
                req_last[i]       = rq[i][0][8];
                req_data[8*i +: 8] = rq[i][0][7:0];
            end else begin
                req[i]            = 1'b0;
                req_last[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
            end
        end
    endtask

    task automatic push_byte(input int i, input logic [7:0] d, input logic last);
        rq[i].push_back({last, d});
    endtask

    task automatic expect_tx(input logic [1:0] i, input logic [7:0] d);
        exp_t e;
        e.is_err = 1'b0;
        e.idx    = i;
        e.data   = d;
        exp_q.push_back(e);
    endtask

    task automatic expect_err();
        exp_t e;
        e.is_err = 1'b1;
        e.idx    = 2'd0;
        e.data   = 8'h00;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) rq[i].delete();
        update_req();
        fall_seen = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || grant_valid || tx_busy ||
                rq[0].size() > 0 || rq[1].size() > 0 ||
                rq[2].size() > 0 || rq[3].size() > 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_drain: %0d expected events left, required 0 within %0d cycles",
                     name, exp_q.size(), budget);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"}, 32'(ack), 32'd0);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_grant_valid"}, 32'(grant_valid), 32'd0);
        check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // Requesters: consume the presented byte when acked
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && ack != 4'd0) begin
                for (int i = 0; i < 4; i++) begin
                    if (ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                end
                update_req();
            end
        end
    end

    // Model transmitter: busy for BUSY_LEN cycles after each tx_start
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start && !busy_dead) begin
                tx_busy  = 1'b1;
                busy_cnt = BUSY_LEN;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    tx_busy       = 1'b0;
                    last_fall_cyc = cyc;
                    fall_seen     = 1'b1;
                end
            end
        end
    end

    // Monitor: compare every frame launch and every err against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (tx_start) begin
                    if (exp_q.size() == 0 || exp_q[0].is_err) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_tx_start: got data %0h from %0d, required none",
                                 tx_data, grant);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_ack", 32'(ack), 32'(4'b0001 << e.idx));
                        check("tx_data", 32'(tx_data), 32'(e.data));
                        check("tx_grant", 32'(grant), 32'(e.idx));
                        check("tx_grant_valid", 32'(grant_valid), 32'd1);
                        if (fall_seen) begin
                            check("busy_fall_to_start_min", 32'((cyc - last_fall_cyc) >= GAP + 2),
                                  32'd1);
                            fall_seen = 1'b0;
                        end
                    end
                    last_start_cyc = cyc;
                end else if (ack != 4'd0) begin
                    checks++;
                    errors++;
                    $display("FAIL stray_ack: got %0b without tx_start, required 0", ack);
                end
                if (err) begin
                    if (exp_q.size() == 0 || !exp_q[0].is_err) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_err: got err=1, required 0");
                    end else begin
                        e = exp_q.pop_front();
                        check("err_delay", 32'(cyc - last_start_cyc), 32'(TOUT));
                        check("err_grant_released", 32'(grant_valid), 32'd0);
                        check("err_no_ack", 32'(ack), 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single requester, two single-byte messages
        push_byte(0, 8'h41, 1'b1);
        push_byte(0, 8'h42, 1'b1);
        update_req();
        expect_tx(2'd0, 8'h41);
        expect_tx(2'd0, 8'h42);
        wait_drain("single", 200);

        // Requesters 1 and 3 together: 1, 3, 1
        do_reset();
        push_byte(1, 8'h11, 1'b1);
        push_byte(1, 8'h12, 1'b1);
        push_byte(3, 8'h31, 1'b1);
        update_req();
        expect_tx(2'd1, 8'h11);
        expect_tx(2'd3, 8'h31);
        expect_tx(2'd1, 8'h12);
        wait_drain("rr13", 300);

        // Three-byte message on 0 while requester 2 waits
        do_reset();
        push_byte(0, 8'hA0, 1'b0);
        push_byte(0, 8'hA1, 1'b0);
        push_byte(0, 8'hA2, 1'b1);
        push_byte(2, 8'hC0, 1'b1);
        push_byte(2, 8'hC1, 1'b1);
        update_req();
`ifdef UART_SCHED_MSG_LOCK_EN
        expect_tx(2'd0, 8'hA0);
        expect_tx(2'd0, 8'hA1);
        expect_tx(2'd0, 8'hA2);
        expect_tx(2'd2, 8'hC0);
        expect_tx(2'd2, 8'hC1);
`else
        expect_tx(2'd0, 8'hA0);
        expect_tx(2'd2, 8'hC0);
        expect_tx(2'd0, 8'hA1);
        expect_tx(2'd2, 8'hC1);
        expect_tx(2'd0, 8'hA2);
`endif
        wait_drain("msg", 500);

        // Transmitter never goes busy: err after each launch, then re-arbitration
        do_reset();
        busy_dead = 1'b1;
        push_byte(1, 8'h55, 1'b1);
        push_byte(1, 8'h56, 1'b1);
        update_req();
        expect_tx(2'd1, 8'h55);
        expect_err();
        expect_tx(2'd1, 8'h56);
        expect_err();
        wait_drain("timeout", 200);
        busy_dead = 1'b0;

        // Move rr_ptr off zero, then reset in the middle of a frame
        do_reset();
        push_byte(1, 8'h21, 1'b1);
        update_req();
        expect_tx(2'd1, 8'h21);
        wait_drain("pre_reset", 200);
        push_byte(3, 8'h77, 1'b1);
        update_req();
        expect_tx(2'd3, 8'h77);
        n = 0;
        while (!tx_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("busy_before_reset", 32'(tx_busy), 32'd1);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (tx_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        fall_seen = 1'b0;
        // rr_ptr back at 0, so requester 0 must win over 3
        push_byte(3, 8'h78, 1'b1);
        push_byte(0, 8'h05, 1'b1);
        update_req();
        expect_tx(2'd0, 8'h05);
        expect_tx(2'd3, 8'h78);
        wait_drain("post_reset", 300);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
